// File: rtl/hart_time_slice_scheduler.sv
// -----------------------------------------------------------------------------
// hart_time_slice_scheduler
//
// Decides which hart owns the shared cluster memory port and MMU. The owner
// keeps the port for a quantum of enabled cycles. Idle harts with nothing
// pending are skipped. Before a switch, the scheduler stalls every core and
// waits until the in-flight interconnect / page-walk traffic has drained, so
// a switch never cuts a transaction in half.
//
// Ports
//   CLK            clock
//   RST            asynchronous, active-high reset
//   i_enable       CPU mode active, no MC-mode transition pending; gates
//                  quantum counting and the start of a switch
//   i_safe[h]      hart h is at a safe point to be descheduled
//   i_idle[h]      hart h is in WFI / has nothing to run
//   i_pending[h]   hart h has an enabled pending interrupt (makes it eligible)
//   i_port_busy    interconnect, TLB or page walk still busy
//   o_hart_sel     current owner of the memory port
//   o_core_stall   per-core stall to the core wrappers
//   o_switch       one-cycle pulse aligned with a changed o_hart_sel
//   o_draining     high while waiting for the port to drain
//   o_quantum_cnt  enabled cycles used so far by the current owner
// -----------------------------------------------------------------------------
module hart_time_slice_scheduler #(
    parameter int N_HARTS   = 2,
    parameter int QUANTUM   = 1024,
    parameter int DRAIN_CYC = 2,
    parameter int SEL_W     = $clog2(N_HARTS + 1)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_enable,
    input  logic [N_HARTS-1:0]         i_safe,
    input  logic [N_HARTS-1:0]         i_idle,
    input  logic [N_HARTS-1:0]         i_pending,
    input  logic                       i_port_busy,
    output logic [SEL_W-1:0]           o_hart_sel,
    output logic [N_HARTS-1:0]         o_core_stall,
    output logic                       o_switch,
    output logic                       o_draining,
    output logic [$clog2(QUANTUM)-1:0] o_quantum_cnt
);

    localparam int CNT_W = $clog2(QUANTUM);
    localparam int DC_W  = $clog2(DRAIN_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM - 1);
    localparam logic [DC_W-1:0]  DC_LOAD = DC_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   w_rr_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DC_W-1:0]    r_dc;
    logic [DC_W-1:0]    w_dc_nxt;
    logic               r_switch;
    logic               w_switch_nxt;

    logic [N_HARTS-1:0] w_elig;
    logic               w_other_elig;
    logic               w_idle_sel;
    logic               w_pend_sel;
    logic               w_safe_sel;
    logic               w_trig;
    logic               w_found;

    // -------------------------------------------------------------------------
    // Eligibility, per-owner views of the hart vectors, switch trigger.
    // The owner's bits are picked with a compare loop so the select index
    // never addresses past N_HARTS.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_elig       = ~i_idle | i_pending;
        w_other_elig = 1'b0;
        w_idle_sel   = 1'b0;
        w_pend_sel   = 1'b0;
        w_safe_sel   = 1'b0;
        for (int h = 0; h < N_HARTS; h++) begin
            if (SEL_W'(h) == r_sel) begin
                w_idle_sel = i_idle[h];
                w_pend_sel = i_pending[h];
                w_safe_sel = i_safe[h];
            end else begin
                w_other_elig = w_other_elig | w_elig[h];
            end
        end
        // Quantum expiry and "owner went idle" are one trigger; a pending
        // interrupt on the owner only cancels the idle cause.
        w_trig = w_other_elig & ((r_cnt == CNT_MAX) | (w_idle_sel & ~w_pend_sel));
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first eligible hart in sel+1 .. sel+N_HARTS-1 with an
    // explicit wrap (N_HARTS need not be a power of two). Falls back to the
    // current owner when nobody else is eligible.
    // -------------------------------------------------------------------------
    always_comb begin
        w_rr_next = r_sel;
        w_found   = 1'b0;
        for (int k = 1; k < N_HARTS; k++) begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (!w_found && w_elig[h] &&
                    (((int'(r_sel) + k) >= N_HARTS) ? (int'(r_sel) + k - N_HARTS)
                                                     : (int'(r_sel) + k)) == h) begin
                    w_rr_next = SEL_W'(h);
                    w_found   = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_cnt_nxt    = r_cnt;
        w_dc_nxt     = r_dc;
        w_switch_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_enable) begin
                    if (r_cnt != CNT_MAX) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                    // An unsafe owner keeps running until it reaches a safe point.
                    if (w_trig && w_safe_sel) begin
                        w_state_nxt = ST_DRAIN;
                        w_dc_nxt    = DC_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                // i_enable is deliberately ignored: a started drain completes.
                if (r_dc != '0) begin
                    w_dc_nxt = r_dc - 1'b1;
                end else if (!i_port_busy) begin
                    w_state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                w_sel_nxt    = w_rr_next;
                w_cnt_nxt    = '0;
                w_switch_nxt = (w_rr_next != r_sel);
                w_state_nxt  = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_RUN;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_dc     <= '0;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dc     <= w_dc_nxt;
            r_switch <= w_switch_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_core_stall = '1;
        if (r_state == ST_RUN) begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (SEL_W'(h) == r_sel) begin
                    o_core_stall[h] = i_port_busy;
                end
            end
        end
    end

    assign o_hart_sel    = r_sel;
    assign o_switch      = r_switch;
    assign o_draining    = (r_state == ST_DRAIN);
    assign o_quantum_cnt = r_cnt;

endmodule

// File: tb/tb_hart_time_slice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hart_time_slice_scheduler
//
// Two scheduler instances (2 harts and 3 harts, QUANTUM=8, DRAIN_CYC=2) share
// one set of stimulus; each is compared every cycle against a behavioural
// model of the scheduling rules, with directed constant checks at the points
// where the timing is known up front.
// -----------------------------------------------------------------------------
module tb_hart_time_slice_scheduler;

    localparam int Q = 8;
    localparam int D = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en;
    logic       busy;
    logic [2:0] idle;
    logic [2:0] pend;
    logic [2:0] safe;

    logic [1:0] sel2;
    logic [1:0] stall2;
    logic       sw2;
    logic       dr2;
    logic [2:0] cnt2;

    logic [1:0] sel3;
    logic [2:0] stall3;
    logic       sw3;
    logic       dr3;
    logic [2:0] cnt3;

    always #5 clk = ~clk;

    hart_time_slice_scheduler #(.N_HARTS(2), .QUANTUM(Q), .DRAIN_CYC(D)) dut2 (
        .CLK           (clk),
        .RST           (rst),
        .i_enable      (en),
        .i_safe        (safe[1:0]),
        .i_idle        (idle[1:0]),
        .i_pending     (pend[1:0]),
        .i_port_busy   (busy),
        .o_hart_sel    (sel2),
        .o_core_stall  (stall2),
        .o_switch      (sw2),
        .o_draining    (dr2),
        .o_quantum_cnt (cnt2)
    );

    hart_time_slice_scheduler #(.N_HARTS(3), .QUANTUM(Q), .DRAIN_CYC(D)) dut3 (
        .CLK           (clk),
        .RST           (rst),
        .i_enable      (en),
        .i_safe        (safe),
        .i_idle        (idle),
        .i_pending     (pend),
        .i_port_busy   (busy),
        .o_hart_sel    (sel3),
        .o_core_stall  (stall3),
        .o_switch      (sw3),
        .o_draining    (dr3),
        .o_quantum_cnt (cnt3)
    );

    // -------------------------------------------------------------------------
    // Reference model: owner, cycles used, remaining drain cycles (-1 when the
    // owner is running) and a flag for the one-cycle handover.
    // -------------------------------------------------------------------------
    typedef struct {
        int sel;
        int cnt;
        int drain_left;
        bit handover;
        bit sw;
    } model_t;

    model_t m2;
    model_t m3;
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;

    function automatic model_t model_reset();
        model_t r;
        r.sel        = 0;
        r.cnt        = 0;
        r.drain_left = -1;
        r.handover   = 1'b0;
        r.sw         = 1'b0;
        return r;
    endfunction

    function automatic bit bit_at(logic [2:0] v, int h);
        return ((v >> h) & 3'b001) != 3'b000;
    endfunction

    function automatic model_t model_step(model_t s, int n, logic [2:0] idle_v,
                                          logic [2:0] pend_v, logic [2:0] safe_v,
                                          logic en_v, logic busy_v);
        model_t     ns;
        logic [2:0] el;
        bit         others;
        bit         trig;
        int         nxt;
        ns     = s;
        ns.sw  = 1'b0;
        el     = ~idle_v | pend_v;
        others = 1'b0;
        for (int h = 0; h < n; h++) begin
            if (h != s.sel && bit_at(el, h)) others = 1'b1;
        end
        if (s.handover) begin
            nxt = s.sel;
            for (int k = n - 1; k >= 1; k--) begin
                if (bit_at(el, (s.sel + k) % n)) nxt = (s.sel + k) % n;
            end
            ns.sw       = (nxt != s.sel);
            ns.sel      = nxt;
            ns.cnt      = 0;
            ns.handover = 1'b0;
        end else if (s.drain_left >= 0) begin
            if (s.drain_left > 0) begin
                ns.drain_left = s.drain_left - 1;
            end else if (!busy_v) begin
                ns.drain_left = -1;
                ns.handover   = 1'b1;
            end
        end else if (en_v) begin
            trig   = others && (s.cnt == Q - 1 ||
                                (bit_at(idle_v, s.sel) && !bit_at(pend_v, s.sel)));
            ns.cnt = (s.cnt < Q - 1) ? s.cnt + 1 : s.cnt;
            if (trig && bit_at(safe_v, s.sel)) ns.drain_left = D - 1;
        end
        return ns;
    endfunction

    function automatic int exp_stall(model_t s, int n, logic busy_v);
        int v;
        v = (1 << n) - 1;
        if (s.drain_left < 0 && !s.handover && !busy_v) v = v & ~(1 << s.sel);
        return v;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("d2.sel",   32'(sel2),   32'(m2.sel));
        check("d2.switch", 32'(sw2),   32'(m2.sw));
        check("d2.drain", 32'(dr2),    32'(m2.drain_left >= 0));
        check("d2.cnt",   32'(cnt2),   32'(m2.cnt));
        check("d2.stall", 32'(stall2), 32'(exp_stall(m2, 2, busy)));
        check("d3.sel",   32'(sel3),   32'(m3.sel));
        check("d3.switch", 32'(sw3),   32'(m3.sw));
        check("d3.drain", 32'(dr3),    32'(m3.drain_left >= 0));
        check("d3.cnt",   32'(cnt3),   32'(m3.cnt));
        check("d3.stall", 32'(stall3), 32'(exp_stall(m3, 3, busy)));
    endtask

    // One clock: advance the models on the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m2 = model_step(m2, 2, idle, pend, safe, en, busy);
            m3 = model_step(m3, 3, idle, pend, safe, en, busy);
        end
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    initial begin
        en   = 1'b1;
        busy = 1'b0;
        idle = 3'b000;
        pend = 3'b000;
        safe = 3'b111;
        rst  = 1'b1;
        m2   = model_reset();
        m3   = model_reset();

        // Reset values
        repeat (2) @(negedge clk);
        compare_all();
        check("rst.sel",   32'(sel2),   32'd0);
        check("rst.drain", 32'(dr2),    32'd0);
        check("rst.cnt",   32'(cnt2),   32'd0);
        check("rst.stall", 32'(stall2), 32'd2);

        // Both harts busy: 0->1 at edge 11, back to 0 at edge 22
        rst = 1'b0;
        repeat (7) tick();
        check("q.cnt_sat", 32'(cnt2), 32'd7);
        tick();
        check("q.drain_enter", 32'(dr2), 32'd1);
        repeat (2) tick();
        check("q.switch_state_stall", 32'(stall2), 32'd3);
        check("q.sel_before", 32'(sel2), 32'd0);
        tick();
        check("q.sel_0to1", 32'(sel2), 32'd1);
        check("q.switch_pulse", 32'(sw2), 32'd1);
        tick();
        check("q.switch_drop", 32'(sw2), 32'd0);
        repeat (10) tick();
        check("q.sel_1to0", 32'(sel2), 32'd0);

        // Owner 0 not safe: quantum expires but no drain until safe returns
        safe = 3'b110;
        repeat (12) tick();
        check("safe.no_drain", 32'(dr2), 32'd0);
        check("safe.cnt_held", 32'(cnt2), 32'd7);
        safe = 3'b111;
        tick();
        check("safe.drain", 32'(dr2), 32'd1);
        repeat (3) tick();
        check("safe.sel", 32'(sel2), 32'd1);

        // Port busy during drain holds DRAIN with everything stalled
        for (int i = 0; i < 20 && m2.drain_left < 0; i++) tick();
        check("busy.wait_drain", 32'(dr2), 32'd1);
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("busy.hold_drain", 32'(dr2), 32'd1);
            check("busy.stall_all", 32'(stall2), 32'd3);
        end
        busy = 1'b0;
        tick();
        check("busy.left_drain", 32'(dr2), 32'd0);
        tick();
        check("busy.sel", 32'(sel2), 32'd0);
        check("busy.pulse", 32'(sw2), 32'd1);

        // Hart 1 idle and skipped, then made eligible by a pending interrupt
        idle = 3'b010;
        repeat (40) tick();
        pend = 3'b010;
        repeat (40) tick();

        // Only hart 0 eligible: counter saturates, no switch
        idle = 3'b110;
        pend = 3'b000;
        repeat (30) tick();
        check("solo.sel2", 32'(sel2), 32'd0);
        check("solo.sel3", 32'(sel3), 32'd0);
        check("solo.cnt2", 32'(cnt2), 32'd7);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("solo.no_switch", 32'(sw2), 32'd0);
            check("solo.no_drain", 32'(dr2), 32'd0);
        end
        idle = 3'b100;
        repeat (4) tick();
        check("solo.rejoin_sel", 32'(sel2), 32'd1);
        check("solo.rejoin_pulse", 32'(sw2), 32'd1);

        // Enable low freezes the quantum counter
        idle = 3'b000;
        repeat (3) tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("en.frozen", 32'(cnt2), 32'd3);
        end
        en = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            en   = ($urandom_range(0, 7) != 0);
            busy = ($urandom_range(0, 2) == 0);
            idle = 3'($urandom()) & 3'($urandom());
            pend = ($urandom_range(0, 3) == 0) ? 3'($urandom()) : 3'b000;
            safe = ($urandom_range(0, 3) == 0) ? 3'($urandom()) : 3'b111;
            tick();
        end

        // Asynchronous reset in the middle of a drain with owner 1
        en   = 1'b1;
        busy = 1'b0;
        idle = 3'b000;
        pend = 3'b000;
        safe = 3'b111;
        rst  = 1'b1;
        m2   = model_reset();
        m3   = model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (19) tick();
        check("arst.pre_sel", 32'(sel2), 32'd1);
        check("arst.pre_drain", 32'(dr2), 32'd1);
        #2;
        rst = 1'b1;
        m2  = model_reset();
        m3  = model_reset();
        #1;
        check("arst.sel", 32'(sel2), 32'd0);
        check("arst.drain", 32'(dr2), 32'd0);
        check("arst.cnt", 32'(cnt2), 32'd0);
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hart_time_slice_scheduler.md
Name: hart_time_slice_scheduler

Overview:
- Time-slice scheduler that decides which hart owns the shared cluster memory port and MMU.
- Replaces the free-running "advance on every safe point" policy with three mechanisms:
  - a per-hart quantum counter;
  - idle-hart skipping;
  - a drain handshake, so a switch never cuts an in-flight interconnect or page-walk transaction.
- Sits in the cluster beside the cores/MMU mux. Drives the hart-select index and the per-core stall mask.

Parameters:
- N_HARTS, 2, number of harts sharing the port (1..8).
- QUANTUM, 1024, enabled cycles a hart may hold the port before a switch is requested (>=2).
- DRAIN_CYC, 2, minimum stall cycles between leaving RUN and committing the new selection (>=1).
- SEL_W, $clog2(N_HARTS+1), width of the select index.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-high reset.
- i_enable  input  1  CPU mode active and no MC-mode transition pending. Quantum counting and switch start only when high.
- i_safe  input  N_HARTS  per-hart safe point: idle next state, interrupt ok, branch resolved, no exception/CSR/TLB flush, no page fault.
- i_idle  input  N_HARTS  hart is in WFI / has nothing to run.
- i_pending  input  N_HARTS  hart has an enabled pending interrupt. Makes an idle hart eligible.
- i_port_busy  input  1  interconnect busy OR MMU tlb_busy OR page walk running.
- o_hart_sel  output  SEL_W  current owner of the memory port.
- o_core_stall  output  N_HARTS  per-core busy/stall to the core wrappers.
- o_switch  output  1  one-cycle pulse in the cycle o_hart_sel changes.
- o_draining  output  1  high in DRAIN.
- o_quantum_cnt  output  $clog2(QUANTUM)  enabled cycles used by the current owner.

Behaviour:
- Reset values (asynchronous, on RST high): o_hart_sel=0, state=RUN, cnt=0, o_switch=0, o_draining=0.
- Eligibility: elig[h] = !i_idle[h] | i_pending[h]. other_elig = OR of elig[h] for h != sel.
- Trigger: trig = other_elig & (cnt==QUANTUM-1 | i_idle[sel] & !i_pending[sel]).
- RUN state:
  - Counter: if i_enable, cnt increments and saturates at QUANTUM-1. Frozen when i_enable=0.
  - Leaving RUN: if i_enable & trig & i_safe[sel], go to DRAIN and load drain counter dc=DRAIN_CYC-1.
  - Waiting: if trig is true but i_safe[sel]=0, stay in RUN (the hart continues to a safe point).
  - No other eligible hart: cnt stays saturated and there is no switch. A switch happens as soon as another hart becomes eligible and sel is safe.
- DRAIN state:
  - All o_core_stall bits are 1.
  - dc decrements to 0.
  - Move to SWITCH when dc==0 and i_port_busy==0. Remain in DRAIN otherwise.
  - i_enable is ignored in DRAIN; a started drain always completes.
- SWITCH state (exactly 1 cycle):
  - next = first h with elig[h] in round-robin order sel+1 ... sel+N_HARTS-1 (mod N_HARTS). The wrap is explicit, not power-of-two.
  - If no hart is eligible at this point, next = sel.
  - o_hart_sel <= next, cnt <= 0, go to RUN.
  - o_switch pulses for one cycle, aligned with the new o_hart_sel value, only if next != sel.
- o_core_stall:
  - RUN: bit sel = i_port_busy; all other bits = 1.
  - DRAIN/SWITCH: all bits 1.
- N_HARTS=1: other_elig=0, so the block stays permanently in RUN with sel=0.
- Latency: a trigger with sel safe gives a new select after DRAIN_CYC+1 cycles minimum (DRAIN cycles + SWITCH).
- Simultaneous events:
  - i_idle[sel] rising in the same cycle as the quantum expiring counts as a single trigger.
  - i_pending on sel clears the idle cause but not the quantum cause.

Test Plan:
- N_HARTS=2, QUANTUM=8, DRAIN_CYC=2, both harts busy, i_safe=2'b11, i_enable=1 -> sel 0->1 at cycle 8+2+1=11 after reset release, o_switch high 1 cycle, then sel 1->0 after a further 11 cycles.
- Same config, i_safe[0] held low cycles 6-15 -> no DRAIN before cycle 16, switch commits at cycle 19.
- i_port_busy high for 5 cycles during DRAIN -> state holds DRAIN, all o_core_stall=1, switch commits the cycle after busy drops.
- N_HARTS=3, i_idle=3'b010, i_pending=0, quantum expires on hart 0 -> next sel=2 (hart 1 skipped). Then set i_pending[1]=1 -> sel 2->0->1 on the following quanta.
- Only hart 0 eligible, QUANTUM=8 -> o_quantum_cnt saturates at 7, no o_switch. Raise elig[1] -> switch within DRAIN_CYC+1 cycles.
- Assert RST in the middle of DRAIN with sel=1 -> o_hart_sel=0, o_draining=0, cnt=0 immediately (asynchronous). Toggle i_enable low during RUN -> cnt frozen at its value.
